// File: rtl/soi_obs_pkg.sv
// soi_obs_pkg: shared record type and default sizing for the signal-of-interest capture block.
package soi_obs_pkg;

    localparam int SOI_W_DEF = 1;
    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;

    typedef struct packed {
        logic [SOI_W_DEF-1:0] data;
        logic [TS_W_DEF-1:0]  ts;
    } soi_rec_t;

endpackage

// File: rtl/soi_fifo.sv
// soi_fifo: synchronous power-of-two FIFO with occupancy; a push into a full FIFO is accepted only alongside a pop.
module soi_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    always_comb begin
        full_o  = level_q == LW'(DEPTH);
        empty_o = level_q == '0;
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        data_o  = empty_o ? '0 : mem_q[rd_q];
        level_o = level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/soi_capture.sv
// soi_capture: timestamps changes of an observed signal into a record FIFO with sticky overflow.
// Optional SOI_CAPTURE_DROP_CNT_EN adds a saturating dropped-record counter on drop_cnt_o.
module soi_capture
    import soi_obs_pkg::*;
#(
    parameter int SOI_W = SOI_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SOI_W-1:0]         soi_i,
    input  logic                     arm_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [SOI_W-1:0]         rec_data_o,
    output logic [TS_W-1:0]          rec_ts_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    input  logic                     clr_ovf_i
`ifdef SOI_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt_o
`endif
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [SOI_W-1:0] prev_q, prev_d;
    logic             first_q, first_d;
    logic             ovf_q, ovf_d;
    logic             evt, pop, drop, full, empty;

    always_comb begin
        ts_d    = ts_q + TS_W'(1);
        prev_d  = soi_i;
        first_d = !arm_i;
        evt     = arm_i && (soi_i != prev_q || first_q);
        pop     = rec_valid_o && rec_ready_i;
        drop    = evt && full && !pop;
        ovf_d   = drop ? 1'b1 : clr_ovf_i ? 1'b0 : ovf_q;
        rec_valid_o = !empty;
        ovf_o   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q    <= '0;
            prev_q  <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
        end
    end

    soi_fifo #(
        .W     (SOI_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (evt),
        .data_i  ({soi_i, ts_q}),
        .pop_i   (rec_ready_i),
        .data_o  ({rec_data_o, rec_ts_o}),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

`ifdef SOI_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Clear and increment together restart the count at one.
    always_comb begin
        drop_cnt_d = clr_ovf_i ? 16'(drop)
                   : (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        drop_cnt_o = drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end
`endif

endmodule

// File: tb/tb_soi_capture.sv
// tb_soi_capture: directed checks of soi_capture with default sizing and a TS_W=4/DEPTH=4 instance.
module tb_soi_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soi = 1'b0;
    logic        arm = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic        valid, ovf, valid4, ovf4;
    logic        data, data4;
    logic [15:0] ts;
    logic [3:0]  ts4;
    logic [3:0]  level;
    logic [2:0]  level4;
`ifdef SOI_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt, drop_cnt4;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    soi_capture u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soi_i       (soi),
        .arm_i       (arm),
        .rec_valid_o (valid),
        .rec_ready_i (ready),
        .rec_data_o  (data),
        .rec_ts_o    (ts),
        .level_o     (level),
        .ovf_o       (ovf),
        .clr_ovf_i   (clr)
`ifdef SOI_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    soi_capture #(.SOI_W(1), .DEPTH(4), .TS_W(4)) u_ts4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .soi_i       (soi),
        .arm_i       (arm),
        .rec_valid_o (valid4),
        .rec_ready_i (ready),
        .rec_data_o  (data4),
        .rec_ts_o    (ts4),
        .level_o     (level4),
        .ovf_o       (ovf4),
        .clr_ovf_i   (clr)
`ifdef SOI_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arm   = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        soi   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and single record from a held-low input armed at ts=5
        do_reset();
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", data, 0);
        check("rst_ts", ts, 0);
        repeat (5) tick();
        arm = 1'b1;
        tick();
        check("arm_valid", valid, 1);
        check("arm_data", data, 0);
        check("arm_ts", ts, 5);
        check("arm_level", level, 1);
        repeat (3) tick();
        check("arm_hold_level", level, 1);

        // Toggle every cycle with the consumer always ready
        do_reset();
        arm = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            soi = k[0];
            tick();
            check("tog_valid", valid, 1);
            check("tog_ts", ts, k);
            check("tog_data", data, k & 1);
            check("tog_level", level, 1);
        end

        // Ten events into an eight-deep FIFO with no consumer
        do_reset();
        arm = 1'b1;
        for (int k = 0; k < 10; k++) begin
            soi = k[0];
            tick();
        end
        check("ovf_level", level, 8);
        check("ovf_flag", ovf, 1);
        check("ovf_head_ts", ts, 0);
`ifdef SOI_CAPTURE_DROP_CNT_EN
        check("ovf_drop_cnt", drop_cnt, 2);
`endif
        soi = 1'b0;
        clr = 1'b1;
        tick();
        check("setwins_ovf", ovf, 1);
`ifdef SOI_CAPTURE_DROP_CNT_EN
        check("setwins_drop_cnt", drop_cnt, 1);
`endif
        arm = 1'b0;
        tick();
        clr = 1'b0;
        check("clr_ovf", ovf, 0);
`ifdef SOI_CAPTURE_DROP_CNT_EN
        check("clr_drop_cnt", drop_cnt, 0);
`endif
        check("clr_level", level, 8);
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", valid, 1);
            check("drain_ts", ts, k);
            check("drain_data", data, k & 1);
            tick();
        end
        check("drain_empty_valid", valid, 0);
        check("drain_empty_level", level, 0);

        // Full FIFO with simultaneous event and pop
        do_reset();
        arm = 1'b1;
        for (int k = 0; k < 8; k++) begin
            soi = k[0];
            tick();
        end
        check("full_level", level, 8);
        check("full_ovf", ovf, 0);
        soi = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("fullpop_level", level, 8);
        check("fullpop_ovf", ovf, 0);
        check("fullpop_head_ts", ts, 1);

        // Timestamp wrap on the 4-bit instance
        do_reset();
        repeat (15) tick();
        arm = 1'b1;
        tick();
        tick();
        soi = 1'b1;
        tick();
        check("wrap_level", level4, 2);
        check("wrap_ts0", ts4, 15);
        check("wrap_data0", data4, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("wrap_ts1", ts4, 1);
        check("wrap_data1", data4, 1);
        check("wrap_level1", level4, 1);

        // Reset mid-operation with a handshake pending
        do_reset();
        arm = 1'b1;
        for (int k = 0; k < 5; k++) begin
            soi = k[0];
            tick();
        end
        check("mid_level", level, 5);
        rst_n = 1'b0;
        ready = 1'b1;
        tick();
        check("midrst_valid", valid, 0);
        check("midrst_level", level, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_data", data, 0);
        check("midrst_ts", ts, 0);
        rst_n = 1'b1;
        ready = 1'b0;
        tick();
        check("rearm_level", level, 1);
        check("rearm_ts", ts, 0);
        check("rearm_data", data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/soi_capture.md
SOI_CAPTURE -- requirements
Module: soi_capture

Interface
REQ-001 The block SHALL have parameter SOI_W, default 1: width of the observed signal-of-interest.
REQ-002 The block SHALL have parameter DEPTH, default 8: record FIFO depth, a power of two, 2 or more.
REQ-003 The block SHALL have parameter TS_W, default 16: timestamp width.
REQ-004 The block SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 The block SHALL have port soi_i  input  SOI_W: the observed signal, sampled every cycle.
REQ-007 The block SHALL have port arm_i  input  1: capture enable.
REQ-008 The block SHALL have port rec_valid_o  output  1: a record is present at the FIFO head.
REQ-009 The block SHALL have port rec_ready_i  input  1: the consumer accepts the head record.
REQ-010 The block SHALL have port rec_data_o  output  SOI_W: the recorded signal value.
REQ-011 The block SHALL have port rec_ts_o  output  TS_W: the record timestamp.
REQ-012 The block SHALL have port level_o  output  $clog2(DEPTH)+1: FIFO occupancy.
REQ-013 The block SHALL have port ovf_o  output  1: sticky flag meaning a record was dropped.
REQ-014 The block SHALL have port clr_ovf_i  input  1: clears ovf_o.

Function
REQ-015 Free-running counter ts_q SHALL increment by 1 every cycle, wrapping from 2^TS_W-1 to 0.
REQ-016 prev_q SHALL load soi_i every cycle, whether or not the block is armed.
REQ-017 Event SHALL fire when arm_i=1 and either soi_i!=prev_q or this is the first armed cycle after reset or after arm_i was 0.
REQ-018 Each event SHALL push the record {soi_i, ts_q} in the same cycle as the event.
REQ-019 A pushed record SHALL appear on rec_valid_o in the next cycle, giving 1-cycle latency into an empty FIFO.
REQ-020 A pop SHALL occur exactly when rec_valid_o and rec_ready_i are both 1.
REQ-021 rec_data_o and rec_ts_o SHALL hold stable while rec_valid_o=1 and rec_ready_i=0.
REQ-022 Full FIFO with an event and no pop: the record SHALL be dropped, ovf_o set to 1 next cycle, and FIFO contents unchanged.
REQ-023 Full FIFO with an event and a pop in the same cycle: the push SHALL be accepted, level unchanged, and ovf_o not set.
REQ-024 Empty FIFO with an event: the pop condition is impossible, so the push SHALL proceed normally.
REQ-025 ovf_o SHALL be cleared by clr_ovf_i; a set condition in the same cycle SHALL win.
REQ-026 level_o SHALL equal pushes minus pops, in the range 0..DEPTH, updated one cycle after the handshake.
REQ-027 Records SHALL be delivered in strict FIFO order; read and write pointers wrap modulo DEPTH.
REQ-028 De-asserting arm_i SHALL stop new events without flushing stored records; draining continues.

Reset
REQ-029 When rst_n=0 at a clock edge, the following SHALL hold next cycle: ts_q=0, prev_q=0, the FIFO empty, rec_valid_o=0, level_o=0, ovf_o=0, rec_data_o=0, rec_ts_o=0, and the first-armed flag set.
REQ-030 Reset asserted mid-operation SHALL discard all stored records, and a consumer handshake in that cycle SHALL be ignored.

Configuration
REQ-031 Macro SOI_CAPTURE_DROP_CNT_EN, when defined, SHALL add output drop_cnt_o, 16 bits, reset to 0, counting dropped records and saturating at 16'hFFFF.
REQ-032 drop_cnt_o SHALL be cleared by clr_ovf_i; an increment in the same cycle SHALL yield 1.
REQ-033 Without SOI_CAPTURE_DROP_CNT_EN, the drop_cnt_o port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package soi_obs_pkg SHALL hold the soi_rec_t struct {data, ts}, and the default constants SOI_W_DEF=1, DEPTH_DEF=8 and TS_W_DEF=16.
REQ-035 Sub-module soi_fifo SHALL implement the synchronous FIFO: parameterised width and depth, push/pop ports, full/empty, and level.
REQ-036 soi_capture SHALL contain the event detect, timestamp, overflow, and the optional drop counter.

Verification
REQ-037 Reset, arm at cycle 5 with soi_i=0 held: exactly one record {0, ts=5} and level_o=1.
REQ-038 Armed, soi_i toggling every cycle, rec_ready_i=1: one record per cycle, ts consecutive, rec_valid_o 1 cycle after each change.
REQ-039 DEPTH=8, rec_ready_i=0, 10 changes: level_o=8, ovf_o=1, drop_cnt_o=2 (macro on), first 8 records kept in order.
REQ-040 FIFO full, event and pop in the same cycle: level_o stays 8, ovf_o stays 0.
REQ-041 TS_W=4, record at ts=15, next change 2 cycles later: second record has ts=1.
REQ-042 rst_n=0 while level_o=5: next cycle rec_valid_o=0, level_o=0, ovf_o=0, and a new armed cycle records the initial sample again.
